alu_packet_responder: RTL and testbench
=======================================

# alu_packet_responder

FPGA-side responder for the UART ALU packet protocol. It consumes the byte stream from the UART receiver's AXI-stream master port and parses each packet header. It then executes echo, 32-bit add, or 32-bit multiply, and returns response bytes on an AXI-stream master port that feeds the UART transmitter. It sits between `uart` rx and tx inside the `icebreaker` top, clocked from the PLL global clock.

## Interface
- No parameters; byte width is fixed at 8 and operand width at 32.
- `clk` in 1: PLL global clock. The only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 8: received byte.
- `s_axis_tvalid` in 1: received byte valid.
- `s_axis_tready` out 1: responder accepts the byte.
- `m_axis_tdata` out 8: response byte.
- `m_axis_tvalid` out 1: response byte valid.
- `m_axis_tready` in 1: transmitter accepts the byte.
- `busy_o` out 1: high whenever state is not OPCODE.
- `err_o` out 1: one-cycle pulse on a malformed or unknown packet.

## Operation
- Packet format:
  - Bytes 0–3 are the header: opcode, reserved, len LSB, len MSB.
  - len is total packet bytes including the header, little-endian, 16-bit.
  - payload = len−4 bytes.
- Opcodes: 0xEC echo, 0xA0 add32, 0xA1 mul32. Any other opcode is unknown.
- States: OPCODE, RSVD, LEN_LO, LEN_HI, ECHO, OPERAND, MUL, RESULT, DRAIN.
- Header states accept one byte each. The reserved byte is ignored.
- In LEN_HI, decode happens on acceptance:
  - len<4: pulse err_o, go to OPCODE with no drain.
  - len==4 and echo: go to OPCODE, no response.
  - unknown opcode: pulse err_o, go to DRAIN if payload>0, else OPCODE.
  - add/mul with payload==0 or payload[1:0]≠0: pulse err_o, go to DRAIN if payload>0, else OPCODE.
  - otherwise go to ECHO or OPERAND.
- ECHO is pass-through:
  - `m_axis_tdata=s_axis_tdata`, `m_axis_tvalid=s_axis_tvalid`, `s_axis_tready=m_axis_tready`.
  - Count payload bytes transferred; go to OPCODE after the last one.
- OPERAND: assemble 32-bit little-endian words.
  - First word loads the accumulator.
  - Later words are added (add32), or handed to MUL (mul32) with s_axis_tready low until the multiply completes.
- After the final word, go to RESULT. The result is 32 bits, wrapping modulo 2^32 (mul keeps the low 32 bits).
- RESULT: emit the accumulator little-endian, 4 bytes, honoring m_axis_tready, then go to OPCODE.
- DRAIN: accept and discard the remaining payload bytes, then go to OPCODE.
- s_axis_tready is low in MUL and RESULT, high in the header states, OPERAND and DRAIN.

## Timing
- Reset values:
  - state OPCODE
  - s_axis_tready 1
  - m_axis_tvalid 0
  - m_axis_tdata 0x00
  - busy_o 0
  - err_o 0
  - accumulator and counters 0
- Reset asserted mid-packet aborts immediately. The next accepted byte is treated as an opcode.
- err_o is registered: it pulses in the cycle after the len MSB is accepted.
- ECHO path is combinational (zero latency) and is the only combinational s→m path.
- add32 response: m_axis_tvalid rises one cycle after the last operand byte is accepted.
- mul32 step: exactly 32 cycles per operand after the operand's fourth byte is accepted, one shift-add per cycle. Returns to OPERAND, or goes to RESULT if it was the last word.
- mul32 response: m_axis_tvalid rises one cycle after MUL completes on the last word.
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata is held stable. The byte index advances only on a handshake.
- Payload counter is 16-bit; len=0xFFFF is legal (payload 65531).

## Structure
- `alu_pkg`:
  - opcode localparams OP_ECHO, OP_ADD, OP_MUL
  - state enum `state_e`
  - HDR_BYTES=4
- Sub-module `mul32_iter` handles the multiply:
  - Inputs: start, a[31:0], b[31:0]. Outputs: done, p[31:0].
  - Sequential shift-add, 32 cycles.
- Top holds the FSM, operand shift register, counters and output mux.

## Test plan
- Echo: EC 00 06 00 41 42 → tx 41 42, no err_o, busy_o low afterward.
- Add: A0 00 0C 00 01 00 00 00 02 00 00 00 → 03 00 00 00.
- Wrap: A0 00 0C 00 FF FF FF FF 02 00 00 00 → 01 00 00 00.
- Multiply: A1 00 10 00 03 00 00 00 05 00 00 00 02 00 00 00 → 1E 00 00 00.
  - s_axis_tready low for 32 cycles after each operand past the first.
- Error: unknown opcode 55 00 06 00 AA BB → no output, one err_o pulse.
  - Immediately following EC 00 05 00 7E → 7E.
- Backpressure/reset:
  - Hold m_axis_tready low 10 cycles during an add result → data held stable, all 4 bytes eventually sent in order.
  - Assert rst_n low mid-OPERAND → all outputs return to reset values, next packet parses correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, header size and FSM state encoding for the UART ALU packet responder.
package alu_pkg;

  localparam logic [7:0]  OP_ECHO   = 8'hEC;
  localparam logic [7:0]  OP_ADD    = 8'hA0;
  localparam logic [7:0]  OP_MUL    = 8'hA1;
  localparam logic [15:0] HDR_BYTES = 16'd4;

  typedef enum logic [3:0] {
    OPCODE,
    RSVD,
    LEN_LO,
    LEN_HI,
    ECHO,
    OPERAND,
    MUL,
    RESULT,
    DRAIN
  } state_e;

  function automatic logic is_alu_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/mul32_iter.sv
// Iterative 32x32 shift-add multiplier keeping the low 32 bits of the product.
module mul32_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] p
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] p_q;
  logic [4:0]  step_q;
  logic        run_q;

  // The 32nd partial sum is presented combinationally alongside done.
  assign p    = p_q + (b_q[0] ? a_q : 32'd0);
  assign done = run_q && (step_q == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      p_q    <= '0;
      step_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      p_q    <= p;
      a_q    <= a_q << 1;
      b_q    <= b_q >> 1;
      step_q <= step_q + 5'd1;
      if (step_q == 5'd31) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_packet_responder.sv
// Parses UART ALU packets, runs echo/add32/mul32 and streams the response bytes back out.
module alu_packet_responder
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  out_idx_q, out_idx_d;
  logic        first_q, first_d;
  logic        err_q, err_d;

  logic [15:0] len;
  logic [15:0] payload;
  logic [31:0] word_in;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_p;

  assign len     = {s_axis_tdata, len_lo_q};
  assign payload = len - HDR_BYTES;
  assign word_in = {s_axis_tdata, word_q};
  assign busy_o  = (state_q != OPCODE);
  assign err_o   = err_q;

  mul32_iter u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (acc_q),
    .b     (word_in),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OPCODE;
      opcode_q   <= '0;
      len_lo_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      out_idx_q  <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_lo_q   <= len_lo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      out_idx_q  <= out_idx_d;
      first_q    <= first_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    len_lo_d      = len_lo_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    word_d        = word_q;
    byte_idx_d    = byte_idx_q;
    out_idx_d     = out_idx_q;
    first_d       = first_q;
    err_d         = 1'b0;
    mul_start     = 1'b0;
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;

    case (state_q)
      OPCODE: if (s_axis_tvalid) begin
        opcode_d = s_axis_tdata;
        state_d  = RSVD;
      end
      RSVD: if (s_axis_tvalid) state_d = LEN_LO;
      LEN_LO: if (s_axis_tvalid) begin
        len_lo_d = s_axis_tdata;
        state_d  = LEN_HI;
      end
      // Whole-packet decode happens as the length MSB is accepted.
      LEN_HI: if (s_axis_tvalid) begin
        cnt_d   = payload;
        state_d = OPCODE;
        if (len < HDR_BYTES) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else if (opcode_q == OP_ECHO) begin
          if (payload != 16'd0) state_d = ECHO;
        end else if (!is_alu_op(opcode_q) || payload == 16'd0 || payload[1:0] != 2'd0) begin
          err_d = 1'b1;
          if (payload != 16'd0) state_d = DRAIN;
        end else begin
          state_d    = OPERAND;
          first_d    = 1'b1;
          byte_idx_d = '0;
        end
      end
      ECHO: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = OPCODE;
        end
      end
      OPERAND: if (s_axis_tvalid) begin
        word_d     = word_in[31:8];
        byte_idx_d = byte_idx_q + 2'd1;
        cnt_d      = cnt_q - 16'd1;
        if (byte_idx_q == 2'd3) begin
          if (first_q) begin
            acc_d   = word_in;
            first_d = 1'b0;
            if (cnt_q == 16'd1) state_d = RESULT;
          end else if (opcode_q == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            acc_d = acc_q + word_in;
            if (cnt_q == 16'd1) state_d = RESULT;
          end
        end
      end
      MUL: begin
        s_axis_tready = 1'b0;
        if (mul_done) begin
          acc_d   = mul_p;
          state_d = (cnt_q == 16'd0) ? RESULT : OPERAND;
        end
      end
      RESULT: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = acc_q[{out_idx_q, 3'b000} +: 8];
        if (m_axis_tready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'd3) state_d = OPCODE;
        end
      end
      DRAIN: if (s_axis_tvalid) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = OPCODE;
      end
      default: state_d = OPCODE;
    endcase
  end

endmodule

// File: tb/tb_alu_packet_responder.sv
// Directed self-checking bench for alu_packet_responder with hand-computed responses.
module tb_alu_packet_responder;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;
  int err_count = 0;
  int low_run = 0;
  int runs[$];
  logic [7:0] rx[$];

  alu_packet_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // Observe handshakes, error pulses and tready-low runs on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) rx.push_back(m_axis_tdata);
      if (err_o) err_count++;
      if (!s_axis_tready) low_run++;
      else if (low_run > 0) begin
        runs.push_back(low_run);
        low_run = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int wait_cycles = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!s_axis_tready) checkOutput("tready_timeout", {31'd0, s_axis_tready}, 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic sendPacket(input byte_q_t pkt);
    rx.delete();
    runs.delete();
    err_count = 0;
    low_run = 0;
    foreach (pkt[i]) applyStimulus(pkt[i]);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rxWord();
    if (rx.size() < 4) return 32'hDEAD_BEEF;
    return {rx[3], rx[2], rx[1], rx[0]};
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd1);
    checkOutput({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    checkOutput({tag, "_tdata"},  {24'd0, m_axis_tdata},  32'd0);
    checkOutput({tag, "_busy"},   {31'd0, busy_o},        32'd0);
    checkOutput({tag, "_err"},    {31'd0, err_o},         32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sendPacket('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42});
    waitIdle("echo");
    checkOutput("echo_count", rx.size(), 2);
    checkOutput("echo_b0", (rx.size() > 0) ? {24'd0, rx[0]} : 32'hFFFF, 32'h41);
    checkOutput("echo_b1", (rx.size() > 1) ? {24'd0, rx[1]} : 32'hFFFF, 32'h42);
    checkOutput("echo_err", err_count, 0);

    sendPacket('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
    waitIdle("add");
    checkOutput("add_count", rx.size(), 4);
    checkOutput("add_result", rxWord(), 32'h0000_0003);

    sendPacket('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00});
    waitIdle("wrap");
    checkOutput("wrap_result", rxWord(), 32'h0000_0001);

    sendPacket('{8'hA1, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
    waitIdle("mul");
    checkOutput("mul_result", rxWord(), 32'h0000_001E);
    checkOutput("mul_runs", runs.size(), 2);
    checkOutput("mul_stall0", (runs.size() > 0) ? runs[0] : -1, 32);
    checkOutput("mul_stall1", (runs.size() > 1) ? runs[1] : -1, 36);

    sendPacket('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
    waitIdle("unknown");
    checkOutput("unknown_out", rx.size(), 0);
    checkOutput("unknown_err", err_count, 1);
    sendPacket('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E});
    waitIdle("echo7e");
    checkOutput("echo7e_count", rx.size(), 1);
    checkOutput("echo7e_b0", (rx.size() > 0) ? {24'd0, rx[0]} : 32'hFFFF, 32'h7E);

    sendPacket('{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    waitIdle("misalign");
    checkOutput("misalign_out", rx.size(), 0);
    checkOutput("misalign_err", err_count, 1);

    sendPacket('{8'hEC, 8'h00, 8'h02, 8'h00});
    waitIdle("shortlen");
    checkOutput("shortlen_err", err_count, 1);
    sendPacket('{8'hEC, 8'h00, 8'h04, 8'h00});
    waitIdle("emptyecho");
    checkOutput("emptyecho_out", rx.size(), 0);
    checkOutput("emptyecho_err", err_count, 0);
    sendPacket('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    waitIdle("echo5a");
    checkOutput("echo5a_b0", (rx.size() > 0) ? {24'd0, rx[0]} : 32'hFFFF, 32'h5A);

    // 0x11223344 + 0x01010101 = 0x12233445, first response byte 0x45 held under backpressure.
    m_axis_tready = 1'b0;
    sendPacket('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h01, 8'h01, 8'h01});
    @(negedge clk);
    checkOutput("bp_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    checkOutput("bp_first", {24'd0, m_axis_tdata}, 32'h45);
    repeat (10) @(negedge clk);
    checkOutput("bp_held", {24'd0, m_axis_tdata}, 32'h45);
    checkOutput("bp_none_sent", rx.size(), 0);
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    waitIdle("bp");
    checkOutput("bp_result", rxWord(), 32'h1223_3445);

    sendPacket('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02});
    rst_n = 1'b0;
    #2;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendPacket('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00});
    waitIdle("postreset");
    checkOutput("postreset_result", rxWord(), 32'h0000_000C);
    checkOutput("postreset_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
